// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage types: addresses, instruction words and the {raw, pc} pair handed to decode.
// Also holds the default reset vector and a word-alignment helper.
package instr_fetch_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;

  typedef struct packed {
    instr_t raw;
    addr_t  pc;
  } fetched_instr_t;

  localparam addr_t RESET_PC_DEFAULT = 32'h8000_0000;

  function automatic addr_t word_align(input addr_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_buffer.sv
// In-order fetch buffer: slots reserved at issue, filled by responses, popped at head in program order.
// Fill lands in a register, so a filled slot is visible at the head one cycle later; pop is gated by the caller.
module instr_fetch_buffer
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_clear,
  input  logic                   i_alloc,
  input  addr_t                  i_alloc_pc,
  input  logic                   i_fill,
  input  instr_t                 i_fill_raw,
  input  logic                   i_pop,
  output fetched_instr_t         o_head,
  output logic                   o_head_filled,
  output logic [$clog2(DEPTH):0] o_allocated,
  output logic [$clog2(DEPTH):0] o_unfilled
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  // Pointers carry one extra wrap bit so occupancy falls out of a subtraction.
  logic [PW-1:0]    r_tail;
  logic [PW-1:0]    r_fill;
  logic [PW-1:0]    r_head;
  logic [DEPTH-1:0] r_filled;
  addr_t            r_pc  [DEPTH];
  instr_t           r_raw [DEPTH];

  logic [IW-1:0] w_tail_idx;
  logic [IW-1:0] w_fill_idx;
  logic [IW-1:0] w_head_idx;

  assign w_tail_idx = r_tail[IW-1:0];
  assign w_fill_idx = r_fill[IW-1:0];
  assign w_head_idx = r_head[IW-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tail   <= '0;
      r_fill   <= '0;
      r_head   <= '0;
      r_filled <= '0;
    end else if (i_clear) begin
      r_tail   <= '0;
      r_fill   <= '0;
      r_head   <= '0;
      r_filled <= '0;
    end else begin
      if (i_alloc) begin
        r_filled[w_tail_idx] <= 1'b0;
        r_tail               <= r_tail + PW'(1);
      end
      if (i_fill) begin
        r_filled[w_fill_idx] <= 1'b1;
        r_fill               <= r_fill + PW'(1);
      end
      if (i_pop) begin
        r_filled[w_head_idx] <= 1'b0;
        r_head               <= r_head + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_alloc) begin
      r_pc[w_tail_idx] <= i_alloc_pc;
    end
    if (i_fill) begin
      r_raw[w_fill_idx] <= i_fill_raw;
    end
  end

  assign o_head        = {r_raw[w_head_idx], r_pc[w_head_idx]};
  assign o_head_filled = r_filled[w_head_idx];
  assign o_allocated   = r_tail - r_head;
  assign o_unfilled    = r_tail - r_fill;

endmodule

// File: rtl/instr_fetch.sv
// Fetch front end: sequential PC, word requests to imem, in-order {raw, pc} delivery to decode.
// Issue stalls when all slots are reserved or stale responses remain; flush combinationally blocks issue and output.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT,
  parameter int    DEPTH    = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  output logic           o_fetched_valid,
  input  logic           i_fetched_ready,
  output fetched_instr_t o_fetched_data,
  output logic           o_mem_req_valid,
  input  logic           i_mem_req_ready,
  output addr_t          o_mem_req_addr,
  input  logic           i_mem_resp_valid,
  input  instr_t         i_mem_resp_data,
  input  logic           i_flush,
  input  addr_t          i_flush_target
);

  localparam int            CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  addr_t         r_pc;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_allocated;
  logic [CW-1:0] w_unfilled;
  logic [CW-1:0] w_resp_dec;
  logic          w_head_filled;
  logic          w_issue;
  logic          w_fill;
  logic          w_drop;
  logic          w_pop;

  assign o_mem_req_valid = !i_flush && (w_allocated < FULL) && (r_drop_cnt == '0);
  assign o_mem_req_addr  = r_pc;
  assign w_issue         = o_mem_req_valid && i_mem_req_ready;

  assign w_fill     = i_mem_resp_valid && (r_drop_cnt == '0) && !i_flush;
  assign w_drop     = i_mem_resp_valid && (r_drop_cnt != '0);
  assign w_resp_dec = {{(CW-1){1'b0}}, i_mem_resp_valid};

  assign o_fetched_valid = w_head_filled && !i_flush;
  assign w_pop           = o_fetched_valid && i_fetched_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_drop_cnt <= '0;
    end else if (i_flush) begin
      // Every reservation still waiting on memory becomes a stale response to swallow.
      r_pc       <= word_align(i_flush_target);
      r_drop_cnt <= r_drop_cnt + w_unfilled - w_resp_dec;
    end else begin
      if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  instr_fetch_buffer #(
    .DEPTH(DEPTH)
  ) u_buffer (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_flush),
    .i_alloc      (w_issue),
    .i_alloc_pc   (r_pc),
    .i_fill       (w_fill),
    .i_fill_raw   (i_mem_resp_data),
    .i_pop        (w_pop),
    .o_head       (o_fetched_data),
    .o_head_filled(w_head_filled),
    .o_allocated  (w_allocated),
    .o_unfilled   (w_unfilled)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed + randomized bench for instr_fetch: memory model with fixed latency and a program-order reference stream.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam addr_t RST_PC = 32'h8000_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           fetched_valid;
  logic           fetched_ready = 1'b1;
  fetched_instr_t fetched_data;
  logic           req_valid;
  logic           req_ready = 1'b1;
  addr_t          req_addr;
  logic           resp_valid = 1'b0;
  instr_t         resp_data = '0;
  logic           flush = 1'b0;
  addr_t          flush_target = '0;

  instr_fetch #(.RESET_PC(RST_PC), .DEPTH(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .o_fetched_valid(fetched_valid),
    .i_fetched_ready(fetched_ready),
    .o_fetched_data (fetched_data),
    .o_mem_req_valid(req_valid),
    .i_mem_req_ready(req_ready),
    .o_mem_req_addr (req_addr),
    .i_mem_resp_valid(resp_valid),
    .i_mem_resp_data(resp_data),
    .i_flush        (flush),
    .i_flush_target (flush_target)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Odd multiplier makes the content a bijection of the address, so stale words are distinguishable.
  function automatic instr_t mem_word(input addr_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stimulus mode knobs, written by the main sequence.
  int mem_lat      = 1;
  bit fr_hold      = 1'b1;
  bit fr_rand      = 1'b0;
  bit req_rdy_hold = 1'b1;
  bit req_rand     = 1'b0;
  int stall        = 0;
  int cyc          = 0;

  // Memory: in-order, fixed latency, one response per accepted request.
  addr_t q_addr[$];
  int    q_due[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        q_addr.delete();
        q_due.delete();
      end else if (req_valid && req_ready) begin
        q_addr.push_back(req_addr);
        q_due.push_back(cyc + mem_lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst && q_due.size() > 0 && q_due[0] == cyc) begin
        resp_valid = 1'b1;
        resp_data  = mem_word(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        resp_valid = 1'b0;
        resp_data  = '0;
      end
    end
  end

  // Ready drivers: held values or random stalls of 0-5 cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (req_rand) begin
        if (stall > 0) begin
          req_ready = 1'b0;
          stall--;
        end else begin
          req_ready = 1'b1;
          stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
        end
      end else begin
        req_ready = req_rdy_hold;
      end
      fetched_ready = fr_rand ? ($urandom_range(0, 3) != 0) : fr_hold;
    end
  end

  // Reference model: the program-order address stream restarts at reset and at each flush target.
  addr_t exp_pc;
  addr_t exp_req;
  int    n_pop = 0;
  int    n_acc = 0;
  addr_t first_pc = '0;
  bit    got_first = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc  = RST_PC;
        exp_req = RST_PC;
      end else if (flush) begin
        check("flush_blocks_fetched", fetched_valid, 1'b0);
        check("flush_blocks_req", req_valid, 1'b0);
        exp_pc  = flush_target & ~32'h3;
        exp_req = flush_target & ~32'h3;
      end else begin
        if (req_valid) begin
          check("req_addr", req_addr, exp_req);
          if (req_ready) begin
            exp_req += 32'd4;
            n_acc++;
          end
        end
        if (fetched_valid && fetched_ready) begin
          check("fetched_pair", fetched_data, {mem_word(exp_pc), exp_pc});
          if (!got_first) begin
            first_pc  = fetched_data.pc;
            got_first = 1'b1;
          end
          exp_pc += 32'd4;
          n_pop++;
        end
      end
    end
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int lat, input bit fr);
    @(negedge clk);
    #1;
    rst = 1'b1;
    flush = 1'b0;
    mem_lat = lat;
    fr_hold = fr;
    fr_rand = 1'b0;
    req_rdy_hold = 1'b1;
    req_rand = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    n_pop = 0;
    n_acc = 0;
    got_first = 1'b0;
  endtask

  initial begin
    // Asynchronous reset values.
    #3 rst = 1'b1;
    #1;
    check("rst_fetched_valid", fetched_valid, 1'b0);
    check("rst_req_valid", req_valid, 1'b1);
    check("rst_req_addr", req_addr, RST_PC);

    // 1-cycle memory, ready high: 2-cycle startup, then one per cycle.
    do_reset(1, 1'b1);
    sample();
    check("startup_c0_valid", fetched_valid, 1'b0);
    check("startup_c0_req", req_valid, 1'b1);
    sample();
    check("startup_c1_valid", fetched_valid, 1'b0);
    sample();
    check("startup_c2_valid", fetched_valid, 1'b1);
    check("startup_c2_pc", fetched_data.pc, RST_PC);
    repeat (30) sample();
    check("throughput_pops", n_pop, 31);

    // Decode stalled for 10 cycles: exactly DEPTH requests, then drain and resume.
    do_reset(1, 1'b0);
    repeat (10) sample();
    check("bp_accepted", n_acc, 4);
    check("bp_req_valid", req_valid, 1'b0);
    check("bp_head_valid", fetched_valid, 1'b1);
    check("bp_head_pc", fetched_data.pc, RST_PC);
    fr_hold = 1'b1;
    sample();
    check("bp_release_req", req_valid, 1'b0);
    sample();
    check("bp_resume_req", req_valid, 1'b1);
    check("bp_resume_addr", req_addr, RST_PC + 32'h10);
    repeat (9) sample();
    check("bp_drain_pops", n_pop, 11);

    // Random request stalls and decode backpressure, 3-cycle memory.
    do_reset(3, 1'b1);
    req_rand = 1'b1;
    fr_rand = 1'b1;
    repeat (400) sample();
    check("rand_progress", n_pop > 40, 1'b1);

    // Random flushes on top of the random traffic.
    n_pop = 0;
    for (int i = 0; i < 600; i++) begin
      next_cycle();
      flush = ($urandom_range(0, 19) == 0);
      flush_target = $urandom;
    end
    next_cycle();
    flush = 1'b0;
    repeat (20) sample();
    check("rand_flush_progress", n_pop > 20, 1'b1);

    // Flush with two requests outstanding and a response in the same cycle.
    do_reset(2, 1'b1);
    next_cycle();
    next_cycle();
    flush = 1'b1;
    flush_target = 32'h0000_1002;
    next_cycle();
    flush = 1'b0;
    sample();
    check("flush1_drop_stall", req_valid, 1'b0);
    sample();
    check("flush1_resume_req", req_valid, 1'b1);
    check("flush1_resume_addr", req_addr, 32'h0000_1000);
    repeat (6) sample();
    check("flush1_first_seen", got_first, 1'b1);
    check("flush1_first_pc", first_pc, 32'h0000_1000);

    // Two back-to-back flushes with responses in flight.
    do_reset(3, 1'b1);
    next_cycle();
    next_cycle();
    next_cycle();
    flush = 1'b1;
    flush_target = 32'h0000_2000;
    next_cycle();
    flush_target = 32'h0000_3000;
    next_cycle();
    flush = 1'b0;
    sample();
    check("flush2_drop_stall", req_valid, 1'b0);
    sample();
    check("flush2_resume_req", req_valid, 1'b1);
    check("flush2_resume_addr", req_addr, 32'h0000_3000);
    repeat (8) sample();
    check("flush2_first_seen", got_first, 1'b1);
    check("flush2_first_pc", first_pc, 32'h0000_3000);

    // PC wraps past the top of the address space; issue resumes the cycle after a clean flush.
    do_reset(1, 1'b1);
    flush = 1'b1;
    flush_target = 32'hFFFF_FFF9;
    next_cycle();
    flush = 1'b0;
    sample();
    check("wrap_c1_req", req_valid, 1'b1);
    check("wrap_c1_addr", req_addr, 32'hFFFF_FFF8);
    sample();
    check("wrap_c2_addr", req_addr, 32'hFFFF_FFFC);
    sample();
    check("wrap_c3_addr", req_addr, 32'h0000_0000);
    repeat (5) sample();
    check("wrap_first_pc", first_pc, 32'hFFFF_FFF8);

    // Reset asserted mid-stream takes effect without a clock edge.
    check("midrst_pre_valid", fetched_valid, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("midrst_fetched_valid", fetched_valid, 1'b0);
    check("midrst_req_valid", req_valid, 1'b1);
    check("midrst_req_addr", req_addr, RST_PC);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    got_first = 1'b0;
    repeat (6) sample();
    check("midrst_first_pc", first_pc, RST_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
